// File: rtl/backlight_pkg.sv
`default_nettype none
// ============================================================================
// Module      : backlight_pkg
// Description : Zone-grid geometry, zone-index type and drain state encoding
//               shared by the local-dimming statistics and filter stages.
// Revision    : 1.0 - initial release
// ============================================================================
package backlight_pkg;

    localparam int ZONE_COLS = 24;
    localparam int ZONE_ROWS = 15;
    localparam int ZONE_NUM  = ZONE_COLS * ZONE_ROWS;

    // Column counter holds 0..ZONE_COLS (one past the end after a full line)
    localparam int COL_W = 5;
    // Zone-row counter holds 0..ZONE_ROWS (saturates past the active area)
    localparam int ROW_W = 4;

    typedef logic [8:0] zone_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_t;

    // Linear zone number, row-major
    function automatic zone_idx_t zone_index(input logic [ROW_W-1:0] zrow,
                                             input logic [COL_W-1:0] col);
        return zone_idx_t'(zrow) * zone_idx_t'(ZONE_COLS) + zone_idx_t'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/zone_mean_pipe.sv
`default_nettype none
// ============================================================================
// Module      : zone_mean_pipe
// Description : Three-stage zone mean pipeline: capture sum, multiply by the
//               reciprocal of the zone pixel count, shift and clamp to 8 bits.
//               The zone index travels alongside as side-band.
// Revision    : 1.0 - initial release
// ============================================================================
module zone_mean_pipe
    import backlight_pkg::*;
#(
    parameter int SUM_W   = 21,
    parameter int RECIP   = 2913,
    parameter int RECIP_W = 12,
    parameter int SHIFT   = 24
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             kill,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    input  zone_idx_t        in_index,
    output logic [15:0]      gray,
    output zone_idx_t        gray_index,
    output logic             gray_update
);

    localparam int c_prod_w = SUM_W + RECIP_W;
    localparam logic [RECIP_W-1:0]  c_recip    = RECIP_W'(RECIP);
    localparam logic [c_prod_w-1:0] c_gray_max = c_prod_w'(255);

    logic                r_s1_valid;
    logic [SUM_W-1:0]    r_s1_sum;
    zone_idx_t           r_s1_idx;
    logic                r_s2_valid;
    logic [c_prod_w-1:0] r_s2_prod;
    zone_idx_t           r_s2_idx;

    logic [c_prod_w-1:0] w_quot;
    logic [7:0]          w_clamp;

    assign w_quot  = r_s2_prod >> SHIFT;
    assign w_clamp = (w_quot > c_gray_max) ? 8'hFF : w_quot[7:0];

    // Pipeline stages; kill drops in-flight zones but gray/gray_index hold
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sum    <= '0;
            r_s1_idx    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_idx    <= '0;
            gray        <= '0;
            gray_index  <= '0;
            gray_update <= 1'b0;
        end else begin
            r_s1_valid  <= in_valid & ~kill;
            r_s2_valid  <= r_s1_valid & ~kill;
            gray_update <= r_s2_valid & ~kill;
            if (in_valid) begin
                r_s1_sum <= in_sum;
                r_s1_idx <= in_index;
            end
            if (r_s1_valid) begin
                r_s2_prod <= c_prod_w'(r_s1_sum) * c_prod_w'(c_recip);
                r_s2_idx  <= r_s1_idx;
            end
            if (r_s2_valid && !kill) begin
                gray       <= {8'd0, w_clamp};
                gray_index <= r_s2_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/zone_stat.sv
`default_nettype none
// ============================================================================
// Module      : zone_stat
// Description : Splits the active-video luminance stream into a 24x15 zone
//               grid, accumulates per-zone sums one zone row at a time and
//               drains the zone means as a (gray, gray_index, gray_update)
//               stream, pulsing process_end after the last zone of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module zone_stat
    import backlight_pkg::*;
#(
    parameter int ZW      = 80,
    parameter int ZH      = 72,
    parameter int SUM_W   = 21,
    parameter int RECIP   = 2913,
    parameter int RECIP_W = 12,
    parameter int SHIFT   = 24
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pix_vs,
    input  logic        pix_de,
    input  logic [7:0]  pix_y,
    output logic [15:0] gray,
    output zone_idx_t   gray_index,
    output logic        gray_update,
    output logic        process_end,
    output logic        overrun
);

    localparam int c_x_w = $clog2(ZW + 1);
    localparam int c_l_w = $clog2(ZH + 1);
    localparam logic [c_x_w-1:0] c_x_last    = c_x_w'(ZW - 1);
    localparam logic [c_l_w-1:0] c_line_last = c_l_w'(ZH - 1);
    localparam logic [COL_W-1:0] c_col_last  = COL_W'(ZONE_COLS - 1);
    localparam logic [COL_W-1:0] c_col_end   = COL_W'(ZONE_COLS);
    localparam logic [ROW_W-1:0] c_row_end   = ROW_W'(ZONE_ROWS);
    localparam zone_idx_t        c_idx_last  = zone_idx_t'(ZONE_NUM - 1);

    logic              r_vs_d;
    logic              r_de_d;
    logic [c_x_w-1:0]  r_x;
    logic [COL_W-1:0]  r_col;
    logic [c_l_w-1:0]  r_line;
    logic [ROW_W-1:0]  r_zrow;
    logic [ROW_W-1:0]  r_zrow_lat;
    logic [COL_W-1:0]  r_rd_col;
    drain_state_t      r_state;
    drain_state_t      w_state_nxt;
    logic [SUM_W-1:0]  w_acc [ZONE_COLS];

    logic w_vs_rise;
    logic w_de_fall;
    logic w_active;
    logic w_drain_start;
    logic w_draining;

    assign w_vs_rise     = pix_vs & ~r_vs_d;
    assign w_de_fall     = r_de_d & ~pix_de;
    assign w_active      = (r_zrow < c_row_end);
    assign w_drain_start = w_de_fall && w_active && (r_line == c_line_last);
    assign w_draining    = (r_state == ST_DRAIN);

    // Edge-detect history for frame sync and active-video qualifier
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_vs_d <= 1'b0;
            r_de_d <= 1'b0;
        end else begin
            r_vs_d <= pix_vs;
            r_de_d <= pix_de;
        end
    end

    // Raster position in zone coordinates; frozen once past the last zone row
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_x    <= '0;
            r_col  <= '0;
            r_line <= '0;
            r_zrow <= '0;
        end else if (w_vs_rise) begin
            r_x    <= '0;
            r_col  <= '0;
            r_line <= '0;
            r_zrow <= '0;
        end else if (w_active) begin
            if (pix_de) begin
                if (r_x == c_x_last) begin
                    r_x <= '0;
                    if (r_col != c_col_end) begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end else if (w_de_fall) begin
                r_x   <= '0;
                r_col <= '0;
                if (r_line == c_line_last) begin
                    r_line <= '0;
                    r_zrow <= r_zrow + 1'b1;
                end else begin
                    r_line <= r_line + 1'b1;
                end
            end
        end
    end

    // Per-column accumulators; a pixel landing on the column being drained wins
    for (genvar c = 0; c < ZONE_COLS; c++) begin : g_acc
        logic [SUM_W-1:0] r_acc;
        logic             w_hit;
        logic             w_clr;

        assign w_hit    = pix_de && w_active && (r_col == COL_W'(c));
        assign w_clr    = w_draining && (r_rd_col == COL_W'(c));
        assign w_acc[c] = r_acc;

        // Accumulate, clear on drain, wipe on frame start
        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
                r_acc <= '0;
            end else if (w_vs_rise) begin
                r_acc <= '0;
            end else if (w_hit) begin
                r_acc <= w_clr ? SUM_W'(pix_y) : r_acc + SUM_W'(pix_y);
            end else if (w_clr) begin
                r_acc <= '0;
            end
        end
    end

    // Drain FSM state register; frame sync aborts any drain in progress
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= ST_IDLE;
        end else if (w_vs_rise) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM next state: 24 issue cycles, then 2 cycles to empty the pipe
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_drain_start) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_rd_col == c_col_last) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_rd_col == COL_W'(1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Read column in DRAIN, doubling as the flush cycle counter; restarts on each state change
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_rd_col <= '0;
        end else if (w_vs_rise || (r_state == ST_IDLE) || (w_state_nxt != r_state)) begin
            r_rd_col <= '0;
        end else begin
            r_rd_col <= r_rd_col + 1'b1;
        end
    end

    // Zone row being drained; r_zrow advances on the same edge that starts the drain
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_zrow_lat <= '0;
        end else if ((r_state == ST_IDLE) && w_drain_start && !w_vs_rise) begin
            r_zrow_lat <= r_zrow;
        end
    end

    // Sticky flag for active video arriving while a drain is still running
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            overrun <= 1'b0;
        end else if (w_vs_rise) begin
            overrun <= 1'b0;
        end else if (pix_de && (r_state != ST_IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Frame-complete pulse one cycle after the strobe carrying the last zone
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            process_end <= 1'b0;
        end else begin
            process_end <= !w_vs_rise && gray_update && (gray_index == c_idx_last);
        end
    end

    zone_mean_pipe #(
        .SUM_W   (SUM_W),
        .RECIP   (RECIP),
        .RECIP_W (RECIP_W),
        .SHIFT   (SHIFT)
    ) u_mean_pipe (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .kill        (w_vs_rise),
        .in_valid    (w_draining),
        .in_sum      (w_acc[r_rd_col]),
        .in_index    (zone_index(r_zrow_lat, r_rd_col)),
        .gray        (gray),
        .gray_index  (gray_index),
        .gray_update (gray_update)
    );

endmodule
`default_nettype wire
